// File: rtl/lms_channel_estimator.sv
// LMS channel estimator: MACs pilot beats against per-channel weights, emits saturated estimates, optionally runs one LMS pass.
// Estimate valid 2 edges after the last beat; pilots stall outside IDLE/ACCUM; estimate held while est_ready is low.
module lms_channel_estimator #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_PILOTS   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int WEIGHT_WIDTH = 18,
    parameter int ACC_WIDTH    = 40,
    parameter int OUT_SHIFT    = 8,
    parameter int MU_SHIFT     = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pilot_valid,
    output logic                               pilot_ready,
    input  logic [DATA_WIDTH-1:0]              pilot_data,
    input  logic                               train_en,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] true_ch,
    output logic                               est_valid,
    input  logic                               est_ready,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] est_data,
    output logic                               err_valid,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] err_data,
    output logic                               sat_flag,
    output logic                               busy,
    input  logic                               wt_wr_en,
    input  logic [$clog2(NUM_CHANNELS)-1:0]    wt_wr_ch,
    input  logic [$clog2(NUM_PILOTS+1)-1:0]    wt_wr_idx,
    input  logic [WEIGHT_WIDTH-1:0]            wt_wr_data
);
    localparam int DW = DATA_WIDTH;
    localparam int WW = WEIGHT_WIDTH;
    localparam int NC = NUM_CHANNELS;
    localparam int NP = NUM_PILOTS;
    localparam int BW = $clog2(NUM_PILOTS);
    localparam int IW = $clog2(NUM_PILOTS + 1);
    localparam int PW = DW + WW;
    localparam int EW = 2 * DW;
    localparam int SW = ACC_WIDTH + EW + 2;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, OUTPUT, ERROR, UPDATE} state_t;

    // Returns {overflow, saturated value}; overflow when the upper bits are not a pure sign extension.
    function automatic logic [DW:0] sat_dw(input logic [SW-1:0] v);
        logic ovf;
        ovf = !((&v[SW-1:DW-1]) || !(|v[SW-1:DW-1]));
        if (!ovf)        sat_dw = {1'b0, v[DW-1:0]};
        else if (v[SW-1]) sat_dw = {2'b11, {(DW-1){1'b0}}};
        else             sat_dw = {2'b10, {(DW-1){1'b1}}};
    endfunction

    function automatic logic [WW:0] sat_ww(input logic [SW-1:0] v);
        logic ovf;
        ovf = !((&v[SW-1:WW-1]) || !(|v[SW-1:WW-1]));
        if (!ovf)        sat_ww = {1'b0, v[WW-1:0]};
        else if (v[SW-1]) sat_ww = {2'b11, {(WW-1){1'b0}}};
        else             sat_ww = {2'b10, {(WW-1){1'b1}}};
    endfunction

    state_t                       r_state, w_state_nxt;
    logic [BW-1:0]                r_beat_cnt;
    logic [IW-1:0]                r_upd_cnt;
    logic                         r_train, r_prod_vld, r_est_vld, r_err_vld, r_sat;
    logic signed [WW-1:0]         r_w    [NC][NP];
    logic signed [WW-1:0]         r_bias [NC];
    logic signed [DW-1:0]         r_pilot[NP];
    logic signed [PW-1:0]         r_prod [NC];
    logic signed [ACC_WIDTH-1:0]  r_acc  [NC];
    logic signed [DW-1:0]         r_est  [NC];
    logic signed [DW-1:0]         r_err  [NC];
    logic [NC*DW-1:0]             r_true;

    logic                         w_beat_acc, w_last_beat, w_wr_ok, w_upd_bias, w_sat_now;
    logic [BW-1:0]                w_upd_idx;
    logic signed [PW-1:0]         w_prod    [NC];
    logic signed [EW-1:0]         w_ep      [NC];
    logic [DW:0]                  w_est_res [NC];
    logic [DW:0]                  w_err_res [NC];
    logic [WW:0]                  w_dlt_res [NC];
    logic [WW:0]                  w_wsum_res[NC];
    logic [WW:0]                  w_bsum_res[NC];

    assign pilot_ready = (r_state == IDLE) || (r_state == ACCUM);
    assign busy        = (r_state != IDLE);
    assign est_valid   = r_est_vld;
    assign err_valid   = r_err_vld;
    assign sat_flag    = r_sat;
    assign w_beat_acc  = pilot_valid && pilot_ready;
    assign w_last_beat = w_beat_acc && (r_state == ACCUM) && (r_beat_cnt == BW'(NP - 1));
    assign w_wr_ok     = wt_wr_en && (r_state == IDLE) && !w_beat_acc;
    assign w_upd_idx   = r_upd_cnt[BW-1:0];
    assign w_upd_bias  = (r_upd_cnt == IW'(NP));

    always_comb begin
        w_sat_now = 1'b0;
        est_data  = '0;
        err_data  = '0;
        for (int c = 0; c < NC; c++) begin
            w_prod[c]     = PW'(r_w[c][r_beat_cnt]) * PW'($signed(pilot_data));
            w_est_res[c]  = sat_dw(SW'(r_acc[c] >>> OUT_SHIFT) + SW'(r_bias[c]));
            w_err_res[c]  = sat_dw(SW'($signed(r_true[c*DW +: DW])) - SW'(r_est[c]));
            w_ep[c]       = EW'(r_err[c]) * EW'(r_pilot[w_upd_idx]);
            w_dlt_res[c]  = sat_ww(SW'(w_ep[c] >>> MU_SHIFT));
            w_wsum_res[c] = sat_ww(SW'(r_w[c][w_upd_idx]) + SW'($signed(w_dlt_res[c][WW-1:0])));
            w_bsum_res[c] = sat_ww(SW'(r_bias[c]) + SW'(r_err[c] >>> MU_SHIFT));
            est_data[c*DW +: DW] = r_est[c];
            err_data[c*DW +: DW] = r_err[c];
            if (r_state == OUTPUT && !r_est_vld && w_est_res[c][DW]) w_sat_now = 1'b1;
            if (r_state == ERROR && w_err_res[c][DW])                w_sat_now = 1'b1;
            if (r_state == UPDATE) begin
                if (w_upd_bias && w_bsum_res[c][WW])                           w_sat_now = 1'b1;
                if (!w_upd_bias && (w_dlt_res[c][WW] || w_wsum_res[c][WW]))   w_sat_now = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_beat_acc) w_state_nxt = ACCUM;
            ACCUM:   if (w_last_beat) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = OUTPUT;
            OUTPUT:  if (r_est_vld && est_ready) w_state_nxt = r_train ? ERROR : IDLE;
            ERROR:   w_state_nxt = UPDATE;
            UPDATE:  if (w_upd_bias) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_upd_cnt  <= '0;
            r_train    <= 1'b0;
            r_prod_vld <= 1'b0;
            r_est_vld  <= 1'b0;
            r_err_vld  <= 1'b0;
            r_sat      <= 1'b0;
            r_true     <= '0;
            for (int p = 0; p < NP; p++) r_pilot[p] <= '0;
            for (int c = 0; c < NC; c++) begin
                r_bias[c] <= '0;
                r_prod[c] <= '0;
                r_acc[c]  <= '0;
                r_est[c]  <= '0;
                r_err[c]  <= '0;
                for (int p = 0; p < NP; p++) r_w[c][p] <= '0;
            end
        end else begin
            r_prod_vld <= w_beat_acc;
            r_err_vld  <= (r_state == ERROR);
            if (w_sat_now) r_sat <= 1'b1;
            if (w_beat_acc) begin
                r_pilot[r_beat_cnt] <= $signed(pilot_data);
                r_beat_cnt <= (r_beat_cnt == BW'(NP - 1)) ? '0 : r_beat_cnt + BW'(1);
            end
            if (w_beat_acc && r_state == IDLE) r_train <= train_en;
            if (w_last_beat) r_true <= true_ch;
            if (r_state == OUTPUT && !r_est_vld)   r_est_vld <= 1'b1;
            else if (r_est_vld && est_ready)       r_est_vld <= 1'b0;
            if (r_state == ERROR)                  r_upd_cnt <= '0;
            else if (r_state == UPDATE)            r_upd_cnt <= r_upd_cnt + IW'(1);
            for (int c = 0; c < NC; c++) begin
                if (w_beat_acc) r_prod[c] <= w_prod[c];
                if (w_beat_acc && r_state == IDLE) r_acc[c] <= '0;
                else if (r_prod_vld)               r_acc[c] <= r_acc[c] + ACC_WIDTH'(r_prod[c]);
                if (r_state == OUTPUT && !r_est_vld) r_est[c] <= $signed(w_est_res[c][DW-1:0]);
                if (r_state == ERROR)                r_err[c] <= $signed(w_err_res[c][DW-1:0]);
                if (r_state == UPDATE) begin
                    if (w_upd_bias) r_bias[c]          <= $signed(w_bsum_res[c][WW-1:0]);
                    else            r_w[c][w_upd_idx]  <= $signed(w_wsum_res[c][WW-1:0]);
                end
            end
            // Host writes only land in IDLE, so they never collide with the LMS update.
            if (w_wr_ok) begin
                if (wt_wr_idx < IW'(NP))       r_w[wt_wr_ch][wt_wr_idx[BW-1:0]] <= $signed(wt_wr_data);
                else if (wt_wr_idx == IW'(NP)) r_bias[wt_wr_ch]                 <= $signed(wt_wr_data);
            end
        end
    end
endmodule

// File: tb/tb_lms_channel_estimator.sv
// Scoreboard bench for lms_channel_estimator: directed frames push expected estimates/errors, a monitor pops on transfer.
module tb_lms_channel_estimator;
    localparam int NP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pilot_valid = 1'b0;
    logic        pilot_ready;
    logic [15:0] pilot_data = '0;
    logic        train_en = 1'b0;
    logic [63:0] true_ch = '0;
    logic        est_valid;
    logic        est_ready = 1'b1;
    logic [63:0] est_data;
    logic        err_valid;
    logic [63:0] err_data;
    logic        sat_flag;
    logic        busy;
    logic        wt_wr_en = 1'b0;
    logic [1:0]  wt_wr_ch = '0;
    logic [3:0]  wt_wr_idx = '0;
    logic [17:0] wt_wr_data = '0;

    int          total = 0;
    int          bad = 0;
    int          err_pulses = 0;
    logic [63:0] exp_est[$];
    logic [63:0] exp_err[$];
    logic [15:0] pil[NP];

    always #5 clk = ~clk;

    lms_channel_estimator #(.MU_SHIFT(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .pilot_valid(pilot_valid), .pilot_ready(pilot_ready), .pilot_data(pilot_data),
        .train_en(train_en), .true_ch(true_ch),
        .est_valid(est_valid), .est_ready(est_ready), .est_data(est_data),
        .err_valid(err_valid), .err_data(err_data),
        .sat_flag(sat_flag), .busy(busy),
        .wt_wr_en(wt_wr_en), .wt_wr_ch(wt_wr_ch), .wt_wr_idx(wt_wr_idx), .wt_wr_data(wt_wr_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: compare every estimate transfer and every error pulse against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && est_valid === 1'b1 && est_ready === 1'b1) begin
                if (exp_est.size() == 0) begin
                    total++; bad++;
                    $display("FAIL est_unexpected: got %h want no transfer", est_data);
                end else check("est_data", est_data, exp_est.pop_front());
            end
            if (rst_n === 1'b1 && err_valid === 1'b1) begin
                err_pulses++;
                if (exp_err.size() == 0) begin
                    total++; bad++;
                    $display("FAIL err_unexpected: got %h want no pulse", err_data);
                end else check("err_data", err_data, exp_err.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    task automatic wr(input int ch, input int idx, input logic [17:0] d);
        wt_wr_en = 1'b1; wt_wr_ch = 2'(ch); wt_wr_idx = 4'(idx); wt_wr_data = d;
        @(posedge clk); #1;
        wt_wr_en = 1'b0;
    endtask

    task automatic load_row(input int ch, input logic [17:0] d);
        for (int p = 0; p < NP; p++) wr(ch, p, d);
    endtask

    task automatic set_pil(input logic [15:0] v);
        for (int p = 0; p < NP; p++) pil[p] = v;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) begin
            total++; bad++;
            $display("FAIL %s: busy=%b after %0d cycles, want 0", name, busy, n);
        end
    endtask

    // Eight back-to-back beats; optionally a host write collides with the first beat.
    task automatic frame(input bit train, input logic [63:0] tru, input bit wr_first);
        pilot_valid = 1'b1; train_en = train; true_ch = tru;
        if (wr_first) begin
            wt_wr_en = 1'b1; wt_wr_ch = 2'd0; wt_wr_idx = 4'd1; wt_wr_data = 18'd0;
        end
        for (int i = 0; i < NP; i++) begin
            pilot_data = pil[i];
            check("pilot_ready_in_frame", {63'd0, pilot_ready}, 64'd1);
            @(posedge clk); #1;
            wt_wr_en = 1'b0;
        end
        pilot_valid = 1'b0;
    endtask

    task automatic reset_outputs_zero(input string tag);
        check({tag, "_est_valid"}, {63'd0, est_valid}, 64'd0);
        check({tag, "_err_valid"}, {63'd0, err_valid}, 64'd0);
        check({tag, "_busy"},      {63'd0, busy}, 64'd0);
        check({tag, "_sat_flag"},  {63'd0, sat_flag}, 64'd0);
        check({tag, "_est_data"},  est_data, 64'd0);
        check({tag, "_err_data"},  err_data, 64'd0);
    endtask

    initial begin
        int pulses0;
        // Reset state
        #1;
        repeat (3) @(posedge clk);
        #1;
        reset_outputs_zero("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_pilot_ready", {63'd0, pilot_ready}, 64'd1);

        // Basic estimate with latency check
        load_row(0, 18'd256);
        set_pil(16'd1024);
        exp_est.push_back(64'h0000_0000_0000_2000);
        frame(1'b0, 64'd0, 1'b0);
        check("busy_after_frame", {63'd0, busy}, 64'd1);
        check("est_valid_edge0", {63'd0, est_valid}, 64'd0);
        @(posedge clk); #1;
        check("est_valid_edge1", {63'd0, est_valid}, 64'd0);
        @(posedge clk); #1;
        check("est_valid_edge2", {63'd0, est_valid}, 64'd1);
        wait_idle("basic_idle");

        // Write while busy is dropped; write while idle lands; beat beats a colliding write
        exp_est.push_back(64'h0000_0000_0000_2000);
        frame(1'b0, 64'd0, 1'b0);
        wr(0, 0, 18'd1000);
        wait_idle("busy_wr_idle");
        exp_est.push_back(64'h0000_0000_0000_2000);
        frame(1'b0, 64'd0, 1'b0);
        wait_idle("after_busy_wr");
        wr(0, 0, 18'd1000);
        exp_est.push_back(64'h0000_0000_0000_2BA0);
        frame(1'b0, 64'd0, 1'b1);
        wait_idle("collide_idle");
        exp_est.push_back(64'h0000_0000_0000_2BA0);
        frame(1'b0, 64'd0, 1'b0);
        wait_idle("post_collide_idle");

        // Varying pilots, per-channel weights, positive and negative bias
        for (int p = 0; p < NP; p++) begin
            wr(1, p, 18'(p + 1));
            pil[p] = 16'(p * 100);
        end
        wr(1, NP, 18'd10);
        wr(2, NP, 18'h3FFFB);
        exp_est.push_back(64'h0000_FFFB_004B_0AF0);
        frame(1'b0, 64'd0, 1'b0);
        wait_idle("varied_idle");

        // Backpressure: estimate held for 5 cycles
        est_ready = 1'b0;
        exp_est.push_back(64'h0000_FFFB_004B_0AF0);
        frame(1'b0, 64'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_est_valid", {63'd0, est_valid}, 64'd1);
            check("bp_est_data", est_data, 64'h0000_FFFB_004B_0AF0);
            check("bp_pilot_ready", {63'd0, pilot_ready}, 64'd0);
            @(posedge clk); #1;
        end
        est_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_est_valid_cleared", {63'd0, est_valid}, 64'd0);
        wait_idle("bp_idle");
        check("sat_flag_clear_before_sat", {63'd0, sat_flag}, 64'd0);

        // Saturation, then sticky flag across a clean frame
        for (int c = 0; c < 4; c++) load_row(c, 18'd131071);
        set_pil(16'd32767);
        exp_est.push_back(64'h7FFF_7FFF_7FFF_7FFF);
        frame(1'b0, 64'd0, 1'b0);
        wait_idle("sat_idle");
        check("sat_flag_set", {63'd0, sat_flag}, 64'd1);
        set_pil(16'd0);
        exp_est.push_back(64'h0000_FFFB_000A_0000);
        frame(1'b0, 64'd0, 1'b0);
        wait_idle("sat2_idle");
        check("sat_flag_sticky", {63'd0, sat_flag}, 64'd1);

        // LMS training frame, then estimate with the adapted weights
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst2_sat_flag", {63'd0, sat_flag}, 64'd0);
        pulses0 = err_pulses;
        set_pil(16'd1024);
        exp_est.push_back(64'd0);
        exp_err.push_back(64'h0400_0400_0400_0400);
        frame(1'b1, 64'h0400_0400_0400_0400, 1'b0);
        wait_idle("train_idle");
        check("err_pulse_count", 64'(err_pulses - pulses0), 64'd1);
        exp_est.push_back(64'h0800_0800_0800_0800);
        frame(1'b0, 64'h0400_0400_0400_0400, 1'b0);
        wait_idle("trained_idle");
        check("err_data_held", err_data, 64'h0400_0400_0400_0400);
        check("train_sat_flag", {63'd0, sat_flag}, 64'd0);

        // Reset after beat 3
        pilot_valid = 1'b1; pilot_data = 16'd1024;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        pilot_valid = 1'b0;
        #1;
        reset_outputs_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_pilot_ready", {63'd0, pilot_ready}, 64'd1);
        exp_est.push_back(64'd0);
        frame(1'b0, 64'd0, 1'b0);
        wait_idle("midrst_zero_idle");
        load_row(0, 18'd256);
        exp_est.push_back(64'h0000_0000_0000_2000);
        frame(1'b0, 64'd0, 1'b0);
        @(posedge clk); #1;
        check("midrst_est_valid_edge1", {63'd0, est_valid}, 64'd0);
        @(posedge clk); #1;
        check("midrst_est_valid_edge2", {63'd0, est_valid}, 64'd1);
        wait_idle("midrst_final_idle");

        repeat (3) @(posedge clk);
        #1;
        check("est_queue_left", 64'(exp_est.size()), 64'd0);
        check("err_queue_left", 64'(exp_err.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
